// File: rtl/sdram_arb_pkg.sv
// Shared types and default parameter values for the SDRAM port arbiter.
//   state_t : arbiter FSM states
//   grant_t : encoding of the current owner, also driven on grant_o
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, GAP} state_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_LDR} grant_t;

  localparam int DEF_ADDR_W        = 24;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_ACCESS_CYCLES = 8;
  localparam int DEF_GAP_CYCLES    = 1;
  localparam int DEF_VID_MAX       = 4;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection for the SDRAM port arbiter.
//   vid_req_i/cpu_req_i/ldr_req_i : pending requests
//   vid_run_i  : consecutive video grants made while others waited
//   vid_max_i  : limit on vid_run_i before video yields
//   rr_i       : 0 = CPU wins a CPU/loader tie, 1 = loader wins
//   grant_o    : grant_t encoding of the winner (G_NONE if no request)
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic       vid_req_i,
  input  logic       cpu_req_i,
  input  logic       ldr_req_i,
  input  logic [3:0] vid_run_i,
  input  logic [3:0] vid_max_i,
  input  logic       rr_i,
  output logic [1:0] grant_o
);

  logic others;
  logic vid_blocked;

  always_comb begin
    others      = cpu_req_i | ldr_req_i;
    // Video yields once it has used up its run while someone else waits.
    vid_blocked = (vid_run_i == vid_max_i) && others;
    grant_o     = G_NONE;
    if (vid_req_i && !vid_blocked) begin
      grant_o = G_VID;
    end else if (cpu_req_i && ldr_req_i) begin
      grant_o = rr_i ? G_LDR : G_CPU;
    end else if (cpu_req_i) begin
      grant_o = G_CPU;
    end else if (ldr_req_i) begin
      grant_o = G_LDR;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one ssdram port between video fetch, Z80 CPU and the ROM/tape
// loader. Each access holds mem_cs_o for ACCESS_CYCLES, then the winner gets
// a one-cycle ack (with read data for reads), then GAP_CYCLES idle cycles.
//   clock, reset_n          : SDRAM-domain clock, async active-low reset
//   vid_*                   : video read port (req/addr in, ack/rdata out)
//   cpu_*                   : CPU read/write port
//   ldr_*                   : loader write-only port
//   mem_*                   : towards ssdram (addr/wdata/cs/oe/we out, rdata in)
//   busy_o                  : FSM is not IDLE
//   grant_o                 : current owner, nonzero from ACCESS through ACK
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int VID_MAX       = DEF_VID_MAX
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_cs_o,
  output logic              mem_oe_o,
  output logic              mem_we_o,
  output logic              busy_o,
  output logic [1:0]        grant_o
);

  localparam logic [7:0] ACC_LOAD  = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0] VID_MAX_W = 4'(VID_MAX);

  state_t            state_q;
  grant_t            grant_q;
  grant_t            pick_grant;
  logic [1:0]        pick_raw;
  logic [7:0]        cnt_q;
  logic [3:0]        vid_run_q;
  logic              rr_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_d;
  logic [DATA_W-1:0] vid_rdata_q, cpu_rdata_q;
  logic              mem_cs_q, mem_oe_q, mem_we_q, busy_q;
  logic              vid_ack_q, cpu_ack_q, ldr_ack_q;
  logic              others_pending;

  sdram_arb_pick u_pick (
    .vid_req_i (vid_req),
    .cpu_req_i (cpu_req),
    .ldr_req_i (ldr_req),
    .vid_run_i (vid_run_q),
    .vid_max_i (VID_MAX_W),
    .rr_i      (rr_q),
    .grant_o   (pick_raw)
  );

  assign pick_grant     = grant_t'(pick_raw);
  assign others_pending = cpu_req | ldr_req;

  // Address/data/direction of whichever port would win this cycle.
  always_comb begin
    addr_d  = vid_addr;
    wdata_d = '0;
    we_d    = 1'b0;
    case (pick_grant)
      G_CPU: begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        we_d    = cpu_we;
      end
      G_LDR: begin
        addr_d  = ldr_addr;
        wdata_d = ldr_wdata;
        we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= G_NONE;
      cnt_q       <= '0;
      vid_run_q   <= '0;
      rr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_grant != G_NONE) begin
            state_q  <= ACCESS;
            busy_q   <= 1'b1;
            grant_q  <= pick_grant;
            cnt_q    <= ACC_LOAD;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_cs_q <= 1'b1;
            mem_oe_q <= ~we_d;
            mem_we_q <= we_d;
            // Only runs of video made at someone else's expense count.
            if (pick_grant == G_VID) begin
              if (!others_pending)
                vid_run_q <= '0;
              else if (vid_run_q != VID_MAX_W)
                vid_run_q <= vid_run_q + 4'd1;
            end else begin
              vid_run_q <= '0;
            end
            if (pick_grant == G_CPU) rr_q <= 1'b1;
            if (pick_grant == G_LDR) rr_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q == 8'd0) begin
            state_q  <= ACK;
            mem_cs_q <= 1'b0;
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (grant_q)
              G_VID: begin
                vid_ack_q   <= 1'b1;
                vid_rdata_q <= mem_rdata_i;
              end
              G_CPU: begin
                cpu_ack_q <= 1'b1;
                if (!mem_we_q) cpu_rdata_q <= mem_rdata_i;
              end
              G_LDR:   ldr_ack_q <= 1'b1;
              default: ;
            endcase
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ACK: begin
          grant_q <= G_NONE;
          if (GAP_CYCLES > 0) begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_cs_o    = mem_cs_q;
  assign mem_oe_o    = mem_oe_q;
  assign mem_we_o    = mem_we_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;
  assign vid_ack     = vid_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign ldr_ack     = ldr_ack_q;
  assign vid_rdata   = vid_rdata_q;
  assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-port SDRAM controller (ssdram, clocked on the SDRAM clock domain) between three requesters in the Lynx core: video fetch, Z80 CPU memory cycles and the ROM/tape loader.
- Sequences each access with a fixed-length chip-select window and returns read data with a one-cycle acknowledge.
- Sits between lynx48 and ssdram in the top-level emu module.

Parameters:
- ADDR_W, 24, SDRAM word address width.
- DATA_W, 8, data width.
- ACCESS_CYCLES, 8, cycles mem_cs_o is held per access (range 2..255).
- GAP_CYCLES, 1, idle cycles after each ack before the next grant (0..15).
- VID_MAX, 4, maximum consecutive video grants while another requester waits (1..15).

Ports:
- clock  in  1  SDRAM-domain clock.
- reset_n  in  1  async active-low reset.
- vid_req  in  1  video read request (level).
- vid_addr  in  ADDR_W  video address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  DATA_W  video read data.
- cpu_req  in  1  CPU request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  completion pulse.
- cpu_rdata  out  DATA_W  CPU read data.
- ldr_req  in  1  loader write request (level).
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader data.
- ldr_ack  out  1  completion pulse.
- mem_addr_o  out  ADDR_W  to ssdram addr_i.
- mem_wdata_o  out  DATA_W  to ssdram data_i.
- mem_rdata_i  in  DATA_W  from ssdram data_o.
- mem_cs_o  out  1  to ssdram cs_i.
- mem_oe_o  out  1  to ssdram oe_i.
- mem_we_o  out  1  to ssdram we_i.
- busy_o  out  1  state is not IDLE.
- grant_o  out  2  0 = none, 1 = vid, 2 = cpu, 3 = ldr.

Behaviour:
- Reset (async, reset_n = 0):
  - All outputs are 0; state is IDLE.
  - vid_run = 0; rr = cpu-first.
  - Reset asserted mid-access drops mem_cs_o immediately. No ack is issued for the aborted access.
- Handshake:
  - A requester holds req, addr, we and wdata stable until its ack.
  - The ack is a single-cycle pulse.
  - req still high in the cycle after ack counts as a new request.
  - rdata is valid from the ack cycle and holds until that port's next read ack. Write acks leave rdata unchanged.
- State machine:
  - IDLE → ACCESS when any req = 1. Winner, address, we and data are latched into registers in this cycle.
  - ACCESS:
    - mem_cs_o = 1; mem_oe_o = ~we; mem_we_o = we.
    - mem_addr_o and mem_wdata_o come from the latched values.
    - A counter runs ACCESS_CYCLES-1 down to 0.
    - At count 0, mem_rdata_i is captured and the state moves to ACK.
  - ACK:
    - mem_cs_o/oe/we = 0.
    - The winner's ack = 1 and its rdata register updates (read only).
    - Next state is GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: counts GAP_CYCLES, then IDLE.
  - Latency: a request first seen in IDLE at cycle N gets its ack at cycle N+ACCESS_CYCLES+1. The next grant is possible at N+ACCESS_CYCLES+2+GAP_CYCLES.
- Arbitration (IDLE only):
  - Video has priority unless vid_run == VID_MAX and (cpu_req | ldr_req).
  - Among CPU and loader, round-robin on the rr bit. rr flips to the other port after each CPU or loader grant.
  - vid_run increments on a video grant while cpu_req | ldr_req, saturating at VID_MAX.
  - vid_run clears on any non-video grant, or on a video grant with no other request pending.
- Boundary cases:
  - Requests arriving during ACCESS/ACK/GAP wait for IDLE.
  - A req dropped before ack (protocol violation) does not abort the access; the ack is still issued.
  - Loader requests are always writes.
  - grant_o is nonzero from ACCESS through ACK and 0 in IDLE/GAP.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, ACCESS, ACK, GAP};
  - grant enum {G_NONE, G_VID, G_CPU, G_LDR};
  - default parameter constants.
- Sub-module sdram_arb_pick: combinational priority/round-robin selector.
  - Inputs: reqs, vid_run, VID_MAX, rr.
  - Output: grant.
  - Verifiable standalone.

Test Plan (ACCESS_CYCLES = 8, GAP_CYCLES = 1, VID_MAX = 4 unless stated):
- Single CPU read:
  - Stimulus: cpu_req = 1, cpu_addr = 0x001234 at cycle 10; memory returns 0xA5.
  - Response: mem_cs_o high cycles 11–18 with mem_oe_o = 1 and mem_addr_o = 0x001234; cpu_ack and cpu_rdata = 0xA5 at cycle 19; busy_o low at cycle 21.
- CPU write:
  - Stimulus: cpu_we = 1, cpu_wdata = 0x3C.
  - Response: mem_we_o = 1, mem_oe_o = 0 and mem_wdata_o = 0x3C during ACCESS; cpu_ack after 9 cycles; cpu_rdata unchanged.
- Video starvation limit:
  - Stimulus: vid_req and cpu_req held continuously.
  - Response: grant_o sequence 1,1,1,1,2,1,1,1,1,2.
- Round-robin:
  - Stimulus: cpu_req and ldr_req held, vid_req = 0.
  - Response: grants alternate 2,3,2,3; each ldr access has mem_we_o = 1.
- Simultaneous arrival:
  - Stimulus: all three reqs rise in the same IDLE cycle.
  - Response: video is granted first, then CPU (rr reset value).
- Reset mid-access:
  - Stimulus: reset_n = 0 at ACCESS count 3.
  - Response: mem_cs_o = 0 with no clock edge; no ack.
  - After release with req still high: a fresh full 8-cycle access, then ack.
